// File: rtl/dma_cmd_pkg.sv
// Shared constants and helpers for the DMA command memory responder.
// Default beat/memory geometry, the byte-address to line-index mapping and stat selector codes.
package dma_cmd_pkg;

  localparam int DMA_DATA_WIDTH = 128;
  localparam int DMA_STRB_WIDTH = DMA_DATA_WIDTH / 8;
  localparam int DMA_PMEM_BYTES = 1048576;
  localparam int DMA_HMEM_BYTES = 32768;
  localparam int DMA_RESP_DEPTH = 4;

  localparam int PMEM_ADDR_W = 26;
  localparam int HMEM_ADDR_W = 24;

  typedef enum logic [1:0] {
    STAT_WR_BEATS  = 2'd0,
    STAT_WR_BURSTS = 2'd1,
    STAT_RD_BEATS  = 2'd2,
    STAT_MAX_CRED  = 2'd3
  } stat_sel_e;

  // Byte address to line index; callers truncate to the memory's line width,
  // which is what makes out-of-range addresses wrap.
  function automatic logic [PMEM_ADDR_W-1:0] line_idx(input logic [PMEM_ADDR_W-1:0] addr,
                                                      input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/dma_resp_fifo.sv
// First-word-fall-through response FIFO; head is zero whenever the FIFO is empty.
module dma_resp_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign head    = valid ? mem[rp] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_data;
  end

endmodule

// File: rtl/dma_cmd_mem_responder.sv
// Core-side DMA command responder: packet/header memory writes, in-order packet reads.
// Optional statistics counters behind `DMA_RESP_STATS_EN.
module dma_cmd_mem_responder
  import dma_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int PMEM_BYTES = DMA_PMEM_BYTES,
  parameter int HMEM_BYTES = DMA_HMEM_BYTES,
  parameter int RESP_DEPTH = DMA_RESP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dma_cmd_wr_en,
  input  logic [PMEM_ADDR_W-1:0] dma_cmd_wr_addr,
  input  logic                   dma_cmd_hdr_wr_en,
  input  logic [HMEM_ADDR_W-1:0] dma_cmd_hdr_wr_addr,
  input  logic [DATA_WIDTH-1:0]  dma_cmd_wr_data,
  input  logic [STRB_WIDTH-1:0]  dma_cmd_wr_strb,
  input  logic                   dma_cmd_wr_last,
  output logic                   dma_cmd_wr_ready,
  input  logic                   dma_cmd_rd_en,
  input  logic [PMEM_ADDR_W-1:0] dma_cmd_rd_addr,
  input  logic                   dma_cmd_rd_last,
  output logic                   dma_cmd_rd_ready,
  output logic                   dma_rd_resp_valid,
  output logic [DATA_WIDTH-1:0]  dma_rd_resp_data,
  input  logic                   dma_rd_resp_ready,
  output logic                   proto_err
`ifdef DMA_RESP_STATS_EN
  ,
  input  logic [1:0]             stat_sel,
  output logic [31:0]            stat_val
`endif
);

  localparam int STRB_LOG2 = $clog2(STRB_WIDTH);
  localparam int PM_LINES  = PMEM_BYTES / STRB_WIDTH;
  localparam int HM_LINES  = HMEM_BYTES / STRB_WIDTH;
  localparam int PM_LW     = $clog2(PM_LINES);
  localparam int HM_LW     = $clog2(HM_LINES);
  localparam int CW        = $clog2(RESP_DEPTH) + 1;

  logic            active;
  logic [CW-1:0]   credits;
  logic            pm_we, hm_we, rd_acc, resp_hs;
  logic [PM_LW-1:0] pm_wl, pm_rl;
  logic [HM_LW-1:0] hm_wl;

  logic [DATA_WIDTH-1:0] pmem [PM_LINES];
  logic [DATA_WIDTH-1:0] hmem [HM_LINES];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  vld_pipe;
  logic [CW-1:0]         fifo_count;

  // active goes high on the first edge after reset release and gates both command ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active <= 1'b0;
    else        active <= 1'b1;
  end

  assign dma_cmd_wr_ready = active;
  assign dma_cmd_rd_ready = active && (credits < CW'(RESP_DEPTH));

  assign hm_we   = dma_cmd_hdr_wr_en && active;
  assign pm_we   = dma_cmd_wr_en && active && !dma_cmd_hdr_wr_en;
  assign rd_acc  = dma_cmd_rd_en && dma_cmd_rd_ready;
  assign resp_hs = dma_rd_resp_valid && dma_rd_resp_ready;

  assign pm_wl = PM_LW'(line_idx(dma_cmd_wr_addr, STRB_LOG2));
  assign pm_rl = PM_LW'(line_idx(dma_cmd_rd_addr, STRB_LOG2));
  assign hm_wl = HM_LW'(line_idx({{(PMEM_ADDR_W-HMEM_ADDR_W){1'b0}}, dma_cmd_hdr_wr_addr},
                                 STRB_LOG2));

  // Credits count reads accepted but not yet handed out; this bounds FIFO occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits   <= '0;
      proto_err <= 1'b0;
    end else begin
      case ({rd_acc, resp_hs})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: ;
      endcase
      if (dma_cmd_wr_en && dma_cmd_hdr_wr_en && active) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pm_we) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (dma_cmd_wr_strb[b]) pmem[pm_wl][b*8 +: 8] <= dma_cmd_wr_data[b*8 +: 8];
    end
  end

  // Separate nonblocking read of the same array gives read-first on a same-line collision.
  always_ff @(posedge clk) begin
    if (rd_acc) ram_q <= pmem[pm_rl];
  end

  always_ff @(posedge clk) begin
    if (hm_we) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (dma_cmd_wr_strb[b]) hmem[hm_wl][b*8 +: 8] <= dma_cmd_wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= 1'b0;
    else        vld_pipe <= rd_acc;
  end

  dma_resp_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_pipe),
    .push_data (ram_q),
    .pop       (dma_rd_resp_ready),
    .head      (dma_rd_resp_data),
    .valid     (dma_rd_resp_valid),
    .count     (fifo_count)
  );

  // Header memory is read by the core through another path; nothing here consumes it.
  logic unused_ok;
  assign unused_ok = ^{dma_cmd_wr_last, dma_cmd_rd_last, fifo_count, hmem[0][0]};

`ifdef DMA_RESP_STATS_EN
  logic [31:0] st_wr_beats, st_wr_bursts, st_rd_beats, st_max_cred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_wr_beats  <= '0;
      st_wr_bursts <= '0;
      st_rd_beats  <= '0;
      st_max_cred  <= '0;
    end else begin
      if (pm_we || hm_we)                      st_wr_beats  <= st_wr_beats + 32'd1;
      if ((pm_we || hm_we) && dma_cmd_wr_last) st_wr_bursts <= st_wr_bursts + 32'd1;
      if (rd_acc)                              st_rd_beats  <= st_rd_beats + 32'd1;
      if (32'(credits) > st_max_cred)          st_max_cred  <= 32'(credits);
    end
  end

  always_comb begin
    stat_val = '0;
    case (stat_sel_e'(stat_sel))
      STAT_WR_BEATS:  stat_val = st_wr_beats;
      STAT_WR_BURSTS: stat_val = st_wr_bursts;
      STAT_RD_BEATS:  stat_val = st_rd_beats;
      STAT_MAX_CRED:  stat_val = st_max_cred;
      default:        stat_val = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_dma_cmd_mem_responder.sv
// Randomized bench for dma_cmd_mem_responder against a queue-based reference model.
module tb_dma_cmd_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dma_cmd_wr_en, dma_cmd_hdr_wr_en, dma_cmd_wr_last, dma_cmd_wr_ready;
  logic [25:0]  dma_cmd_wr_addr, dma_cmd_rd_addr;
  logic [23:0]  dma_cmd_hdr_wr_addr;
  logic [127:0] dma_cmd_wr_data, dma_rd_resp_data;
  logic [15:0]  dma_cmd_wr_strb;
  logic         dma_cmd_rd_en, dma_cmd_rd_last, dma_cmd_rd_ready;
  logic         dma_rd_resp_valid, dma_rd_resp_ready, proto_err;

  dma_cmd_mem_responder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dma_cmd_wr_en       (dma_cmd_wr_en),
    .dma_cmd_wr_addr     (dma_cmd_wr_addr),
    .dma_cmd_hdr_wr_en   (dma_cmd_hdr_wr_en),
    .dma_cmd_hdr_wr_addr (dma_cmd_hdr_wr_addr),
    .dma_cmd_wr_data     (dma_cmd_wr_data),
    .dma_cmd_wr_strb     (dma_cmd_wr_strb),
    .dma_cmd_wr_last     (dma_cmd_wr_last),
    .dma_cmd_wr_ready    (dma_cmd_wr_ready),
    .dma_cmd_rd_en       (dma_cmd_rd_en),
    .dma_cmd_rd_addr     (dma_cmd_rd_addr),
    .dma_cmd_rd_last     (dma_cmd_rd_last),
    .dma_cmd_rd_ready    (dma_cmd_rd_ready),
    .dma_rd_resp_valid   (dma_rd_resp_valid),
    .dma_rd_resp_data    (dma_rd_resp_data),
    .dma_rd_resp_ready   (dma_rd_resp_ready),
    .proto_err           (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    int           t;
  } exp_t;

  // Reference state: packet memory lines 0..63, pending responses, outstanding reads.
  logic [127:0] pm [64];
  exp_t         q [$];
  int           outst, cyc, n_chk, n_fail;
  logic         active_m, proto_m;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pline(input logic [25:0] a);
    return (int'(a) / 16) % 65536;
  endfunction

  function automatic logic [25:0] rnd_addr(input int line);
    return 26'(((($urandom % 64) << 20) | (line << 4) | ($urandom % 16)));
  endfunction

  // One clock: compare outputs to the model, then advance the model across the edge.
  task automatic tick();
    logic exp_rdy, exp_v, racc, rhs, we_p;
    int   pl, wl;
    exp_rdy = active_m && (outst < 4);
    exp_v   = (q.size() > 0) && (q[0].t <= cyc);
    chk("rd_ready", 128'(dma_cmd_rd_ready), 128'(exp_rdy));
    chk("wr_ready", 128'(dma_cmd_wr_ready), 128'(active_m));
    chk("resp_valid", 128'(dma_rd_resp_valid), 128'(exp_v));
    chk("proto_err", 128'(proto_err), 128'(proto_m));
    if (exp_v) chk("resp_data", dma_rd_resp_data, q[0].d);
    else if (!rst_n) chk("resp_data_rst", dma_rd_resp_data, 128'd0);
    racc = rst_n && dma_cmd_rd_en && exp_rdy;
    rhs  = rst_n && exp_v && dma_rd_resp_ready;
    we_p = rst_n && active_m && dma_cmd_wr_en && !dma_cmd_hdr_wr_en;
    pl   = pline(dma_cmd_rd_addr);
    wl   = pline(dma_cmd_wr_addr);
    @(posedge clk);
    if (!rst_n) begin
      active_m = 1'b0; q.delete(); outst = 0; proto_m = 1'b0;
    end else begin
      if (rhs) begin void'(q.pop_front()); outst--; end
      if (racc) begin q.push_back('{pm[pl], cyc + 2}); outst++; end
      if (we_p)
        for (int b = 0; b < 16; b++)
          if (dma_cmd_wr_strb[b]) pm[wl][b*8 +: 8] = dma_cmd_wr_data[b*8 +: 8];
      if (active_m && dma_cmd_wr_en && dma_cmd_hdr_wr_en) proto_m = 1'b1;
      active_m = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wr(input logic [25:0] a, input logic [127:0] d, input logic [15:0] s);
    dma_cmd_wr_en = 1'b1; dma_cmd_wr_addr = a; dma_cmd_wr_data = d; dma_cmd_wr_strb = s;
    tick();
    dma_cmd_wr_en = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [25:0] a, input logic [127:0] d);
    dma_cmd_rd_en = 1'b1; dma_cmd_rd_addr = a;
    tick();
    dma_cmd_rd_en = 1'b0;
    tick();
    chk({tag, "_valid"}, 128'(dma_rd_resp_valid), 128'd1);
    chk(tag, dma_rd_resp_data, d);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    active_m = 1'b0; q.delete(); outst = 0; proto_m = 1'b0;
  endtask

  initial begin
    logic [127:0] v_t2, v_pm32, ff_v;
    int acc, saw;
    n_chk = 0; n_fail = 0; cyc = 0; outst = 0;
    dma_cmd_wr_en = 0; dma_cmd_hdr_wr_en = 0; dma_cmd_wr_last = 0; dma_cmd_rd_en = 0;
    dma_cmd_rd_last = 0; dma_cmd_wr_addr = 0; dma_cmd_rd_addr = 0; dma_cmd_hdr_wr_addr = 0;
    dma_cmd_wr_data = 0; dma_cmd_wr_strb = 0; dma_rd_resp_ready = 1'b1;
    do_reset();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    tick();
    // test 1: ready one cycle after release, write then read back with 2-cycle latency
    chk("t1_wr_ready", 128'(dma_cmd_wr_ready), 128'd1);
    chk("t1_rd_ready", 128'(dma_cmd_rd_ready), 128'd1);
    for (int l = 0; l < 64; l++) wr(26'(l * 16), {4{$urandom}}, 16'hFFFF);
    wr(26'h40, {16{8'hA5}}, 16'hFFFF);
    rd_expect("t1_data", 26'h40, {16{8'hA5}});

    // test 2: partial strobe
    wr(26'h100, {16{8'h11}}, 16'hFFFF);
    wr(26'h100, {16{8'h22}}, 16'h00FF);
    v_t2 = {{8{8'h11}}, {8{8'h22}}};
    rd_expect("t2_data", 26'h100, v_t2);

    // test 3: backpressure caps outstanding reads at 4
    dma_rd_resp_ready = 1'b0; acc = 0;
    dma_cmd_rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dma_cmd_rd_addr = rnd_addr(i);
      if (dma_cmd_rd_ready) acc++;
      tick();
    end
    chk("t3_accepted", 128'(acc), 128'd4);
    chk("t3_rd_ready_full", 128'(dma_cmd_rd_ready), 128'd0);
    dma_rd_resp_ready = 1'b1;
    for (int i = 0; i < 20 && acc < 6; i++) begin
      dma_cmd_rd_addr = rnd_addr(10 + acc);
      if (dma_cmd_rd_ready) acc++;
      tick();
    end
    dma_cmd_rd_en = 1'b0;
    chk("t3_total", 128'(acc), 128'd6);
    idle(6);

    // test 4: same-cycle write/read is read-first; next-cycle read sees the new data
    wr(26'h80, 128'd0, 16'hFFFF);
    ff_v = {16{8'hFF}};
    dma_cmd_wr_en = 1'b1; dma_cmd_wr_addr = 26'h80; dma_cmd_wr_data = ff_v;
    dma_cmd_wr_strb = 16'hFFFF; dma_cmd_rd_en = 1'b1; dma_cmd_rd_addr = 26'h80;
    tick();
    dma_cmd_wr_en = 1'b0;
    tick();
    dma_cmd_rd_en = 1'b0;
    chk("t4_old", dma_rd_resp_data, 128'd0);
    tick();
    chk("t4_new", dma_rd_resp_data, ff_v);
    idle(3);

    // test 5: simultaneous writes -> header wins, sticky error
    v_pm32 = pm[32];
    dma_cmd_hdr_wr_en = 1'b1; dma_cmd_hdr_wr_addr = 24'h40;
    wr(26'h200, {16{8'h33}}, 16'hFFFF);
    dma_cmd_hdr_wr_en = 1'b0;
    chk("t5_proto", 128'(proto_err), 128'd1);
    idle(3);
    chk("t5_sticky", 128'(proto_err), 128'd1);
    chk("t5_hdr", dut.hmem[4], {16{8'h33}});
    rd_expect("t5_pkt", 26'h200, v_pm32);

    // test 6: reset with reads in flight
    dma_rd_resp_ready = 1'b0; dma_cmd_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin dma_cmd_rd_addr = rnd_addr(i); tick(); end
    dma_cmd_rd_en = 1'b0;
    do_reset();
    idle(2);
    rst_n = 1'b1;
    dma_rd_resp_ready = 1'b1;
    tick();
    saw = 0;
    for (int i = 0; i < 6; i++) begin saw += int'(dma_rd_resp_valid); tick(); end
    chk("t6_no_resp", 128'(saw), 128'd0);
    chk("t6_rd_ready", 128'(dma_cmd_rd_ready), 128'd1);
    rd_expect("t6_data", 26'h100, v_t2);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      dma_cmd_wr_en       = ($urandom % 3) == 0;
      dma_cmd_hdr_wr_en   = ($urandom % 16) == 0;
      dma_cmd_wr_addr     = rnd_addr($urandom % 64);
      dma_cmd_hdr_wr_addr = 24'($urandom);
      dma_cmd_wr_data     = {4{$urandom}};
      dma_cmd_wr_strb     = 16'($urandom);
      dma_cmd_wr_last     = $urandom % 2;
      dma_cmd_rd_en       = $urandom % 2;
      dma_cmd_rd_addr     = rnd_addr($urandom % 64);
      dma_cmd_rd_last     = $urandom % 2;
      dma_rd_resp_ready   = ($urandom % 4) != 0;
      tick();
    end
    dma_cmd_wr_en = 0; dma_cmd_hdr_wr_en = 0; dma_cmd_rd_en = 0; dma_rd_resp_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("drain_empty", 128'(q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
